// File: rtl/pipe_stage_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_buffer_pkg
// Description : Shared pipeline types for the rv32i core. Stage top levels
//               pack these structs into the flat payload vector that
//               pipe_stage_buffer carries between stages.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_stage_buffer_pkg;

    typedef logic [31:0] data_t;
    typedef logic        enable_t;
    typedef logic [4:0]  reg_addr_t;

    // Occupancy encoding presented on count_o.
    typedef logic [1:0]  occ_t;

    localparam occ_t c_OCC_EMPTY = 2'd0;
    localparam occ_t c_OCC_ONE   = 2'd1;
    localparam occ_t c_OCC_TWO   = 2'd2;

    typedef struct packed {
        data_t pc;
        data_t instr;
    } if_id_t;

    typedef struct packed {
        data_t     pc;
        data_t     rs1_val;
        data_t     rs2_val;
        data_t     imm;
        reg_addr_t rd;
        enable_t   reg_we;
        enable_t   mem_re;
        enable_t   mem_we;
    } id_ex_t;

    typedef struct packed {
        data_t     alu_res;
        data_t     store_val;
        reg_addr_t rd;
        enable_t   reg_we;
        enable_t   mem_re;
        enable_t   mem_we;
    } ex_mem_t;

    typedef struct packed {
        data_t     wb_val;
        reg_addr_t rd;
        enable_t   reg_we;
    } mem_wb_t;

endpackage
`default_nettype wire

// File: rtl/pipe_stage_buffer_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that sticks at its all-ones value instead of
//               wrapping. Used for back-pressure and performance counters.
// Ports       : clk   - clock
//               rst   - synchronous active-high reset, clears value
//               inc   - count this cycle
//               value - current count
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int W = 16
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic         inc,
    output      logic [W-1:0] value
);

    localparam logic [W-1:0] c_ONE = W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            value <= '0;
        end else if (inc && (value != '1)) begin
            value <= value + c_ONE;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pipe_stage_buffer.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_buffer
// Description : Payload-agnostic valid/ready pipeline-stage register. With
//               SKID_EN=1 it holds up to two entries and in_ready_o is a pure
//               decode of registered state; with SKID_EN=0 it holds one entry
//               and in_ready_o follows out_ready_i combinationally.
// Ports       : clk, rst              - clock, synchronous active-high reset
//               flush_c_i             - discard all held entries
//               in_valid_i/in_ready_o/in_data_i    - upstream handshake
//               out_valid_o/out_ready_i/out_data_o - downstream handshake
//               count_o               - entries held (0..2)
//               bp_cycles_o           - saturating count of stalled cycles
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_buffer
    import pipe_stage_buffer_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int SKID_EN = 1,
    parameter int CNT_W   = 16
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              flush_c_i,
    input  wire logic              in_valid_i,
    output      logic              in_ready_o,
    input  wire logic [DATA_W-1:0] in_data_i,
    output      logic              out_valid_o,
    input  wire logic              out_ready_i,
    output      logic [DATA_W-1:0] out_data_o,
    output      logic [1:0]        count_o,
    output      logic [CNT_W-1:0]  bp_cycles_o
);

    // Encoding doubles as the occupancy value on count_o.
    typedef enum logic [1:0] {
        EMPTY = c_OCC_EMPTY,
        ONE   = c_OCC_ONE,
        TWO   = c_OCC_TWO
    } buf_state_t;

    buf_state_t        r_state;
    buf_state_t        w_state_nxt;
    logic [DATA_W-1:0] r_main;
    logic [DATA_W-1:0] r_skid;

    logic w_in_fire;
    logic w_out_fire;
    logic w_load_main_in;
    logic w_load_main_skid;
    logic w_load_skid;

    assign out_valid_o = (r_state != EMPTY);
    assign out_data_o  = r_main;
    assign count_o     = r_state;
    assign w_in_fire   = in_valid_i & in_ready_o;
    assign w_out_fire  = out_valid_o & out_ready_i;

    generate
        if (SKID_EN != 0) begin : g_ready_skid
            // Registered decode only: no path from out_ready_i.
            assign in_ready_o = (r_state != TWO);
        end else begin : g_ready_comb
            assign in_ready_o = ~out_valid_o | out_ready_i;
        end
    endgenerate

    always_comb begin
        w_state_nxt      = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        case (r_state)
            EMPTY: begin
                if (w_in_fire) begin
                    w_state_nxt    = ONE;
                    w_load_main_in = 1'b1;
                end
            end
            ONE: begin
                if (w_in_fire && w_out_fire) begin
                    w_load_main_in = 1'b1;
                end else if (w_in_fire) begin
                    // Only reachable with the skid entry enabled: the
                    // single-entry ready blocks in_fire without out_fire.
                    w_state_nxt = TWO;
                    w_load_skid = 1'b1;
                end else if (w_out_fire) begin
                    w_state_nxt = EMPTY;
                end
            end
            TWO: begin
                if (w_out_fire) begin
                    w_state_nxt      = ONE;
                    w_load_main_skid = 1'b1;
                end
            end
            default: begin
                w_state_nxt = EMPTY;
            end
        endcase
        // Flush drops everything, including a beat accepted this cycle.
        if (flush_c_i) begin
            w_state_nxt      = EMPTY;
            w_load_main_in   = 1'b0;
            w_load_main_skid = 1'b0;
            w_load_skid      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= EMPTY;
            r_main  <= '0;
            r_skid  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load_main_in) begin
                r_main <= in_data_i;
            end else if (w_load_main_skid) begin
                r_main <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= in_data_i;
            end
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_bp_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (out_valid_o & ~out_ready_i),
        .value (bp_cycles_o)
    );

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage_buffer
// Description : Drives a skid instance (SKID_EN=1, CNT_W=3) and a single-entry
//               instance (SKID_EN=0, CNT_W=16) from shared inputs and compares
//               both against a FIFO-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        out_ready = 1'b0;

    logic        rdy [2];
    logic        vld [2];
    logic [31:0] dat [2];
    logic [1:0]  cnt [2];
    logic [2:0]  bp_s;
    logic [15:0] bp_n;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: each buffer is a FIFO of capacity 2 (skid) or 1.
    logic [31:0] mq    [2][2];
    int          msz   [2];
    int          mbp   [2];
    bit          mzero [2];
    bit          m_init = 1'b0;

    always #5 clk = ~clk;

    pipe_stage_buffer #(.DATA_W(32), .SKID_EN(1), .CNT_W(3)) dut_skid (
        .clk         (clk),
        .rst         (rst),
        .flush_c_i   (flush),
        .in_valid_i  (in_valid),
        .in_ready_o  (rdy[0]),
        .in_data_i   (in_data),
        .out_valid_o (vld[0]),
        .out_ready_i (out_ready),
        .out_data_o  (dat[0]),
        .count_o     (cnt[0]),
        .bp_cycles_o (bp_s)
    );

    pipe_stage_buffer #(.DATA_W(32), .SKID_EN(0), .CNT_W(16)) dut_single (
        .clk         (clk),
        .rst         (rst),
        .flush_c_i   (flush),
        .in_valid_i  (in_valid),
        .in_ready_o  (rdy[1]),
        .in_data_i   (in_data),
        .out_valid_o (vld[1]),
        .out_ready_i (out_ready),
        .out_data_o  (dat[1]),
        .count_o     (cnt[1]),
        .bp_cycles_o (bp_n)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // One clock cycle: drive inputs, check pre-edge outputs, advance model.
    task automatic step(input bit r, input bit f, input bit v,
                        input logic [31:0] d, input bit ordy);
        bit exp_rdy [2];
        bit ifire;
        bit ofire;
        int bpmax;
        @(negedge clk);
        rst = r; flush = f; in_valid = v; in_data = d; out_ready = ordy;
        #1;
        for (int k = 0; k < 2; k++) begin
            exp_rdy[k] = (k == 0) ? (msz[k] < 2) : ((msz[k] == 0) || ordy);
            if (m_init) begin
                check($sformatf("dut%0d_in_ready", k), {31'd0, rdy[k]}, {31'd0, exp_rdy[k]});
                check($sformatf("dut%0d_out_valid", k), {31'd0, vld[k]}, {31'd0, msz[k] > 0});
                check($sformatf("dut%0d_count", k), {30'd0, cnt[k]}, 32'(msz[k]));
                check($sformatf("dut%0d_bp_cycles", k),
                      (k == 0) ? {29'd0, bp_s} : {16'd0, bp_n}, 32'(mbp[k]));
                if (msz[k] > 0)
                    check($sformatf("dut%0d_out_data", k), dat[k], mq[k][0]);
                else if (mzero[k])
                    check($sformatf("dut%0d_out_data_rst", k), dat[k], 32'd0);
            end
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            bpmax = (k == 0) ? 7 : 65535;
            if (r) begin
                msz[k] = 0; mbp[k] = 0; mzero[k] = 1'b1;
            end else if (m_init) begin
                if ((msz[k] > 0) && !ordy && (mbp[k] < bpmax)) mbp[k]++;
                if (f) begin
                    msz[k] = 0;
                end else begin
                    ifire = v && exp_rdy[k];
                    ofire = (msz[k] > 0) && ordy;
                    if (ofire) begin
                        mq[k][0] = mq[k][1];
                        msz[k]--;
                    end
                    if (ifire) begin
                        mq[k][msz[k]] = d;
                        msz[k]++;
                        mzero[k] = 1'b0;
                    end
                end
            end
        end
        if (r) m_init = 1'b1;
    endtask

    initial begin
        // Reset held two cycles with a valid beat offered.
        step(1, 0, 1, 32'hDEAD_BEEF, 0);
        step(1, 0, 1, 32'hDEAD_BEEF, 0);
        // Streaming 1..8 with downstream always ready.
        for (int i = 1; i <= 8; i++) step(0, 0, 1, 32'(i), 1);
        step(0, 0, 0, 32'h0, 1);
        step(0, 0, 0, 32'h0, 1);
        // Skid fill, then drain (single-entry instance takes only 0xA).
        step(0, 0, 1, 32'hA, 0);
        step(0, 0, 1, 32'hB, 0);
        step(0, 0, 0, 32'h0, 0);
        step(0, 0, 0, 32'h0, 1);
        step(0, 0, 0, 32'h0, 1);
        step(0, 0, 0, 32'h0, 1);
        // Hold one entry stalled long enough to saturate the 3-bit counter.
        step(0, 0, 1, 32'hC0DE, 0);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 32'h0, 0);
        // Single entry: ready follows out_ready, and in/out fire together.
        step(0, 0, 1, 32'h1234, 1);
        step(0, 0, 1, 32'h5678, 1);
        step(0, 0, 0, 32'h0, 1);
        step(0, 0, 0, 32'h0, 1);
        // Fill to TWO, then flush while offering 0x55.
        step(0, 0, 1, 32'h11, 0);
        step(0, 0, 1, 32'h22, 0);
        step(0, 1, 1, 32'h55, 1);
        step(0, 0, 0, 32'h0, 1);
        step(0, 0, 0, 32'h0, 1);
        // Randomized traffic with occasional flush and reset.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 5,
                 $urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0);
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
